// File: rtl/ws281x_bit_timing_sel.sv
// rtl/ws281x_bit_timing_sel.sv - WS281x per-bit high/period count selector (optional clamp: WS281X_CONF_CLAMP_EN)
module ws281x_bit_timing_sel #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             bit_vld_i,
  input  logic             bit_data_i,
  input  logic [CNT_W-1:0] t0h_cnt_i,
  input  logic [CNT_W-1:0] t0s_cnt_i,
  input  logic [CNT_W-1:0] t1h_cnt_i,
  input  logic [CNT_W-1:0] t1s_cnt_i,
  output logic [CNT_W-1:0] tim_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    PERIOD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             bit_q;
  logic             bit_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] high_sel;
  logic [CNT_W-1:0] high_cnt;

  // High count for the incoming bit, chosen by the bit value on the load edge
  assign high_sel = bit_data_i ? t1h_cnt_i : t0h_cnt_i;

`ifdef WS281X_CONF_CLAMP_EN
  logic [CNT_W-1:0] new_period;

  assign new_period = bit_data_i ? t1s_cnt_i : t0s_cnt_i;

  // Keep the low phase non-empty: high must stay below period, floor at zero
  always_comb begin
    high_cnt = high_sel;
    if (high_sel >= new_period) begin
      if (new_period == '0) begin
        high_cnt = '0;
      end else begin
        high_cnt = new_period - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end
`else
  assign high_cnt = high_sel;
`endif

  // Next-state and next-count: a new valid bit always restarts from its high count
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_q;
    cnt_nxt   = cnt_q;
    if (bit_vld_i) begin
      bit_nxt   = bit_data_i;
      cnt_nxt   = high_cnt;
      state_nxt = HIGH;
    end else begin
      case (state)
        HIGH: begin
          cnt_nxt   = bit_q ? t1s_cnt_i : t0s_cnt_i;
          state_nxt = PERIOD;
        end
        PERIOD:  state_nxt = PERIOD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, latched bit and output count registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      bit_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      bit_q <= bit_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign tim_cnt_o = cnt_q;

endmodule

// File: tb/tb_ws281x_bit_timing_sel.sv
// tb/tb_ws281x_bit_timing_sel.sv - scoreboard bench for ws281x_bit_timing_sel
module tb_ws281x_bit_timing_sel;

  logic       clk;
  logic       rst_n;
  logic       bit_vld;
  logic       bit_data;
  logic [7:0] t0h;
  logic [7:0] t0s;
  logic [7:0] t1h;
  logic [7:0] t1s;
  logic [7:0] tim_cnt;

  logic [7:0] sb[$];
  logic [7:0] exp;
  int         vectors;
  int         miscompares;

  ws281x_bit_timing_sel #(.CNT_W(8)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .bit_vld_i  (bit_vld),
    .bit_data_i (bit_data),
    .t0h_cnt_i  (t0h),
    .t0s_cnt_i  (t0s),
    .t1h_cnt_i  (t1h),
    .t1s_cnt_i  (t1s),
    .tim_cnt_o  (tim_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_cfg(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    t0h = a; t0s = b; t1h = c; t1s = d;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (tim_cnt !== 8'h00) begin
      $display("FAIL reset_async got %02h want 00", tim_cnt);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(8'h00);
      @(posedge clk); @(negedge clk);
      exp = sb.pop_front();
      vectors++;
      if (tim_cnt !== exp) begin
        $display("FAIL reset_idle cyc%0d got %02h want %02h", i, tim_cnt, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_zero_bit();
    set_cfg(8'h01, 8'h80, 8'hFE, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      bit_vld  = (i == 0);
      bit_data = 1'b0;
      sb.push_back((i == 0) ? 8'h01 : 8'h80);
      @(posedge clk); @(negedge clk);
      exp = sb.pop_front();
      vectors++;
      if (tim_cnt !== exp) begin
        $display("FAIL zero_bit cyc%0d got %02h want %02h", i, tim_cnt, exp);
        miscompares++;
      end
    end
    bit_vld = 1'b0;
  endtask

  task automatic test_one_bit();
    set_cfg(8'h01, 8'h80, 8'hFE, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      bit_vld  = (i == 0);
      bit_data = (i == 0);
      // timing inputs change after the loads; output must not follow
      if (i == 3) set_cfg(8'h11, 8'h22, 8'h33, 8'h44);
      sb.push_back((i == 0) ? 8'hFE : 8'hFF);
      @(posedge clk); @(negedge clk);
      exp = sb.pop_front();
      vectors++;
      if (tim_cnt !== exp) begin
        $display("FAIL one_bit cyc%0d got %02h want %02h", i, tim_cnt, exp);
        miscompares++;
      end
    end
    bit_vld = 1'b0;
    set_cfg(8'h01, 8'h80, 8'hFE, 8'hFF);
  endtask

  task automatic test_back_to_back();
    logic       v[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       d[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] e[4] = '{8'h01, 8'hFE, 8'hFF, 8'hFF};
    set_cfg(8'h01, 8'h80, 8'hFE, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      bit_vld  = v[i];
      bit_data = d[i];
      sb.push_back(e[i]);
      @(posedge clk); @(negedge clk);
      exp = sb.pop_front();
      vectors++;
      if (tim_cnt !== exp) begin
        $display("FAIL back_to_back cyc%0d got %02h want %02h", i, tim_cnt, exp);
        miscompares++;
      end
    end
    bit_vld = 1'b0;
  endtask

  task automatic test_held_vld();
    logic       v[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       d[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] e[5] = '{8'h01, 8'hFE, 8'hFE, 8'hFF, 8'hFF};
    set_cfg(8'h01, 8'h80, 8'hFE, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      bit_vld  = v[i];
      bit_data = d[i];
      sb.push_back(e[i]);
      @(posedge clk); @(negedge clk);
      exp = sb.pop_front();
      vectors++;
      if (tim_cnt !== exp) begin
        $display("FAIL held_vld cyc%0d got %02h want %02h", i, tim_cnt, exp);
        miscompares++;
      end
    end
    bit_vld = 1'b0;
  endtask

  task automatic test_mid_bit_reset();
    set_cfg(8'h01, 8'h80, 8'hFE, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      bit_vld  = (i == 0);
      bit_data = 1'b1;
      sb.push_back((i == 0) ? 8'hFE : 8'hFF);
      @(posedge clk); @(negedge clk);
      exp = sb.pop_front();
      vectors++;
      if (tim_cnt !== exp) begin
        $display("FAIL pre_reset cyc%0d got %02h want %02h", i, tim_cnt, exp);
        miscompares++;
      end
    end
    bit_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (tim_cnt !== 8'h00) begin
      $display("FAIL mid_bit_reset got %02h want 00", tim_cnt);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit_vld  = (i == 2);
      bit_data = 1'b0;
      sb.push_back((i < 2) ? 8'h00 : ((i == 2) ? 8'h01 : 8'h80));
      @(posedge clk); @(negedge clk);
      exp = sb.pop_front();
      vectors++;
      if (tim_cnt !== exp) begin
        $display("FAIL post_reset cyc%0d got %02h want %02h", i, tim_cnt, exp);
        miscompares++;
      end
    end
    bit_vld = 1'b0;
  endtask

  task automatic test_clamp();
    logic [7:0] e[4];
`ifdef WS281X_CONF_CLAMP_EN
    e = '{8'h7F, 8'h80, 8'h00, 8'h00};
`else
    e = '{8'hFF, 8'h80, 8'h05, 8'h00};
`endif
    set_cfg(8'h05, 8'h00, 8'hFF, 8'h80);
    for (int i = 0; i < 4; i++) begin
      bit_vld  = (i == 0) || (i == 2);
      bit_data = (i == 0);
      sb.push_back(e[i]);
      @(posedge clk); @(negedge clk);
      exp = sb.pop_front();
      vectors++;
      if (tim_cnt !== exp) begin
        $display("FAIL clamp cyc%0d got %02h want %02h", i, tim_cnt, exp);
        miscompares++;
      end
    end
    bit_vld = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    bit_vld     = 1'b0;
    bit_data    = 1'b0;
    set_cfg(8'h01, 8'h80, 8'hFE, 8'hFF);
    test_reset();
    test_zero_bit();
    test_one_bit();
    test_back_to_back();
    test_held_vld();
    test_mid_bit_reset();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
